// File: rtl/square_pkg.sv
// Shared constants and types for the square sprite motion controller.
//   H_RES, V_RES, SIZE : default screen and sprite geometry
//   reg_addr_t         : MMIO register select
//   vel_t              : 4-bit signed per-axis velocity
//   motion_state_t     : motion FSM states
package square_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam int unsigned SIZE  = 16;

  typedef enum logic [1:0] {
    AddrPos  = 2'd0,
    AddrVel  = 2'd1,
    AddrCtrl = 2'd2,
    AddrRun  = 2'd3
  } reg_addr_t;

  typedef logic signed [3:0] vel_t;

  typedef enum logic {
    StPause = 1'b0,
    StRun   = 1'b1
  } motion_state_t;

  // -8 has no positive mirror in 4 bits, so it is pulled in to -7 to keep reflection symmetric.
  function automatic vel_t sat_vel(input logic [3:0] raw);
    return (raw == 4'b1000) ? vel_t'(4'b1001) : vel_t'(raw);
  endfunction

endpackage

// File: rtl/square_axis_step.sv
// Combinational single-axis step with edge reflection.
//   pos      : current origin on this axis
//   d        : signed velocity
//   max      : largest legal origin on this axis
//   pos_next : stepped origin, clamped to 0..max
//   d_next   : velocity, negated on a reflection
//   hit      : this axis reflected
module square_axis_step
  import square_pkg::*;
(
  input  logic [10:0] pos,
  input  vel_t        d,
  input  logic [10:0] max,
  output logic [10:0] pos_next,
  output vel_t        d_next,
  output logic        hit
);

  logic signed [11:0] n;
  logic signed [11:0] max_s;

  always_comb begin
    n        = signed'({1'b0, pos}) + signed'({{8{d[3]}}, d});
    max_s    = signed'({1'b0, max});
    pos_next = pos;
    d_next   = d;
    hit      = 1'b0;
    if (n < 12'sd0) begin
      pos_next = '0;
      d_next   = -d;
      hit      = 1'b1;
    end else if (n > max_s) begin
      pos_next = max;
      d_next   = -d;
      hit      = 1'b1;
    end else begin
      pos_next = n[10:0];
    end
  end

endmodule

// File: rtl/square_motion.sv
// Per-frame motion controller for a 16x16 square sprite.
// Holds the origin, a signed velocity and a control word; steps the origin every div+1 frames
// and reflects it off the screen edges.
//   clk, reset          : system clock, synchronous active-high reset
//   x, y                : current scan position
//   wr_en/wr_addr/wr_data : register write port (0 pos, 1 vel, 2 ctrl, 3 div/run)
//   x0, y0, ctrl        : sprite origin and control word
//   bounce              : one-cycle pulse when a step reflected on any axis
//   running             : FSM is in RUN
// Build option: define SQUARE_BOUNCE_COLOR_EN to advance ctrl[4:3] on each bounce.
module square_motion #(
  parameter int unsigned H_RES = square_pkg::H_RES,
  parameter int unsigned V_RES = square_pkg::V_RES,
  parameter int unsigned SIZE  = square_pkg::SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic        bounce,
  output logic        running
);
  import square_pkg::*;

  localparam logic [10:0] XMax = 11'(H_RES - SIZE);
  localparam logic [10:0] YMax = 11'(V_RES - SIZE);

  motion_state_t state_q, state_d;
  logic [10:0]   x0_q, x0_d, y0_q, y0_d, x_d1_q;
  vel_t          dx_q, dx_d, dy_q, dy_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [3:0]    div_q, div_d, fcnt_q, fcnt_d;
  logic          bounce_q, bounce_d, running_q, running_d;

  logic          frame_tick, step;
  logic [10:0]   x_step, y_step;
  vel_t          dx_step, dy_step;
  logic          hit_x, hit_y;

  square_axis_step u_step_x (
    .pos      (x0_q),
    .d        (dx_q),
    .max      (XMax),
    .pos_next (x_step),
    .d_next   (dx_step),
    .hit      (hit_x)
  );

  square_axis_step u_step_y (
    .pos      (y0_q),
    .d        (dy_q),
    .max      (YMax),
    .pos_next (y_step),
    .d_next   (dy_step),
    .hit      (hit_y)
  );

  // Start of frame: scan just moved from x=0 to x=1 on line 0.
  assign frame_tick = (x_d1_q == 11'd0) && (x == 11'd1) && (y == 11'd0);
  assign step       = (state_q == StRun) && frame_tick && (fcnt_q == div_q);

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    fcnt_d   = fcnt_q;
    bounce_d = step && (hit_x || hit_y);

    if ((state_q == StRun) && frame_tick) begin
      fcnt_d = step ? 4'd0 : fcnt_q + 4'd1;
    end

    if (step) begin
      x0_d = x_step;
      y0_d = y_step;
      dx_d = dx_step;
      dy_d = dy_step;
`ifdef SQUARE_BOUNCE_COLOR_EN
      if (hit_x || hit_y) begin
        ctrl_d[4:3] = ctrl_q[4:3] + 2'd1;
      end
`endif
    end

    // Writes applied last so the addressed register beats a coincident step.
    if (wr_en) begin
      case (reg_addr_t'(wr_addr))
        AddrPos: begin
          x0_d = (wr_data[10:0] > XMax) ? XMax : wr_data[10:0];
          y0_d = (wr_data[26:16] > YMax) ? YMax : wr_data[26:16];
        end
        AddrVel: begin
          dx_d = sat_vel(wr_data[3:0]);
          dy_d = sat_vel(wr_data[11:8]);
        end
        AddrCtrl: begin
          ctrl_d = wr_data[4:0];
        end
        AddrRun: begin
          div_d = wr_data[3:0];
          if (wr_data[8] && (state_q == StPause)) begin
            state_d = StRun;
          end else if (!wr_data[8] && (state_q == StRun)) begin
            state_d = StPause;
            fcnt_d  = 4'd0;
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StPause;
      x0_q      <= '0;
      y0_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      ctrl_q    <= '0;
      div_q     <= '0;
      fcnt_q    <= '0;
      bounce_q  <= 1'b0;
      running_q <= 1'b0;
      x_d1_q    <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      fcnt_q    <= fcnt_d;
      bounce_q  <= bounce_d;
      running_q <= running_d;
      x_d1_q    <= x;
    end
  end

  assign x0      = x0_q;
  assign y0      = y0_q;
  assign ctrl    = ctrl_q;
  assign bounce  = bounce_q;
  assign running = running_q;

endmodule
